// File: rtl/seg7_capture_if.sv
// Display bus between a multiplexed 7-segment drive and the capture block.
// The master side drives the active-low segment/digit lines; the slave side
// returns the decoded nibbles and status pulses.
interface seg7_capture_if #(
  parameter int DIGITS = 4,
  parameter int IDX_W  = 2
);
  logic [6:0]          iSEG;
  logic [DIGITS-1:0]   iDIG_N;
  logic [4*DIGITS-1:0] oHEX;
  logic [DIGITS-1:0]   oERR;
  logic                oUPD;
  logic [IDX_W-1:0]    oIDX;
  logic                oFRAME;

  modport master (
    output iSEG, iDIG_N,
    input  oHEX, oERR, oUPD, oIDX, oFRAME
  );

  modport slave (
    input  iSEG, iDIG_N,
    output oHEX, oERR, oUPD, oIDX, oFRAME
  );
endinterface

// File: rtl/seg7_capture.sv
// Reads back a time-multiplexed, active-low 7-segment display. The combined
// digit-select/segment word must stay identical for STABLE_CYCLES edges before
// it is decoded into a hex nibble and stored against the selected digit.
module seg7_capture #(
  parameter int DIGITS        = 4,
  parameter int IDX_W         = 2,
  parameter int STABLE_CYCLES = 8
) (
  input logic          iCLK,
  input logic          iRST,
  seg7_capture_if.slave bus
);

  localparam int SW    = DIGITS + 7;
  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 2);

  logic [SW-1:0]       sample_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] hex_q, hex_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                upd_q, upd_d;
  logic                frame_q, frame_d;

  logic [SW-1:0]     sampleNow;
  logic              isSame;
  logic              capture;
  logic [DIGITS-1:0] digSel;
  logic              selOne;
  logic [IDX_W-1:0]  selIdx;
  logic [DIGITS-1:0] seenHit;
  logic              decValid;
  logic [3:0]        decNib;

  // Inverse of the standard hex-to-7-segment encoder; bit 4 flags a known pattern.
  function automatic logic [4:0] decodeSeg(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h18:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // Stability tracking: any change restarts the run, and the counter parks at
  // its top value so a long steady period yields exactly one capture.
  always_comb begin
    sampleNow = {bus.iDIG_N, bus.iSEG};
    isSame    = (sampleNow == sample_q);
    cnt_d     = '0;
    if (isSame) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
    capture = isSame && (cnt_q == CNT_PRE);
  end

  // Digit-select qualification and segment decode of the held sample.
  always_comb begin
    digSel = ~sample_q[SW-1:7];
    selOne = (digSel != '0) && ((digSel & (digSel - DIGITS'(1))) == '0);
    selIdx = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digSel[k]) selIdx = IDX_W'(k);
    end
    {decValid, decNib} = decodeSeg(sample_q[6:0]);
  end

  // Capture result: update the selected digit, mark it seen, and close a frame
  // once every digit has been captured at least once.
  always_comb begin
    hex_d   = hex_q;
    err_d   = err_q;
    idx_d   = idx_q;
    seen_d  = seen_q;
    upd_d   = 1'b0;
    frame_d = 1'b0;
    seenHit = seen_q | digSel;
    if (capture && selOne) begin
      upd_d = 1'b1;
      idx_d = selIdx;
      for (int k = 0; k < DIGITS; k++) begin
        if (digSel[k]) begin
          if (decValid) begin
            hex_d[4*k +: 4] = decNib;
            err_d[k]        = 1'b0;
          end else begin
            err_d[k] = 1'b1;
          end
        end
      end
      if (seenHit == '1) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d = seenHit;
      end
    end
  end

  // State registers; reset abandons any run by reloading the blank sample.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sample_q <= '1;
      cnt_q    <= '0;
      hex_q    <= '0;
      err_q    <= '0;
      seen_q   <= '0;
      idx_q    <= '0;
      upd_q    <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      sample_q <= sampleNow;
      cnt_q    <= cnt_d;
      hex_q    <= hex_d;
      err_q    <= err_d;
      seen_q   <= seen_d;
      idx_q    <= idx_d;
      upd_q    <= upd_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.oHEX   = hex_q;
  assign bus.oERR   = err_q;
  assign bus.oIDX   = idx_q;
  assign bus.oUPD   = upd_q;
  assign bus.oFRAME = frame_q;

endmodule
